// File: rtl/rr_logb_serializer.sv
// Turns one record/replay logging-bus transaction into a packet made of a
// header beat and then one beat for each asserted logb channel, in ascending channel order.
module rr_logb_serializer #(
  parameter int LOGB_CHANNEL_CNT = 4,
  parameter int LOGE_CHANNEL_CNT = 4,
  parameter int CH_WIDTH         = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LOGB_CHANNEL_CNT-1:0]          logb_valid,
  input  logic [LOGB_CHANNEL_CNT*CH_WIDTH-1:0] logb_data,
  input  logic [LOGE_CHANNEL_CNT-1:0]          loge_valid,
  output logic                                 ready,
  output logic                                 out_valid,
  output logic [CH_WIDTH-1:0]                  out_data,
  output logic                                 out_last,
  input  logic                                 out_ready,
  output logic [31:0]                          pkt_cnt,
  output logic                                 busy
);

  // state   | meaning
  // IDLE    | ready high, waiting for any logb/loge valid
  // HDR     | presenting header {loge_mask, logb_mask}
  // DATA    | presenting lowest pending logb channel slice
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int MASK_W = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
  localparam logic [LOGB_CHANNEL_CNT-1:0] PEND_ONE = 1;

  logic [1:0]                           state_q, state_d;
  logic [LOGB_CHANNEL_CNT-1:0]          logb_mask_q, logb_mask_d;
  logic [LOGE_CHANNEL_CNT-1:0]          loge_mask_q, loge_mask_d;
  logic [LOGB_CHANNEL_CNT*CH_WIDTH-1:0] data_q, data_d;
  logic [LOGB_CHANNEL_CNT-1:0]          pending_q, pending_d;
  logic [31:0]                          pkt_cnt_q, pkt_cnt_d;

  logic                        present;
  logic [LOGB_CHANNEL_CNT-1:0] low_oh;
  logic                        pend_single;
  logic [CH_WIDTH-1:0]         hdr_word;
  logic [CH_WIDTH-1:0]         sel_word;

  assign present = (|logb_valid) | (|loge_valid);

  // Isolate the lowest set bit; a single-bit vector leaves nothing after removing it.
  assign low_oh      = pending_q & (~pending_q + PEND_ONE);
  assign pend_single = (pending_q != '0) && ((pending_q & (pending_q - PEND_ONE)) == '0);

  always_comb begin
    hdr_word               = '0;
    hdr_word[MASK_W-1:0]   = {loge_mask_q, logb_mask_q};
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      if (low_oh[i]) sel_word = data_q[i*CH_WIDTH +: CH_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    logb_mask_d = logb_mask_q;
    loge_mask_d = loge_mask_q;
    data_d      = data_q;
    pending_d   = pending_q;
    pkt_cnt_d   = pkt_cnt_q;
    ready       = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (present) begin
          logb_mask_d = logb_valid;
          loge_mask_d = loge_valid;
          data_d      = logb_data;
          pending_d   = logb_valid;
          state_d     = ST_HDR;
        end
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_word;
        out_last  = (logb_mask_q == '0);
        if (out_ready) begin
          if (out_last) begin
            state_d   = ST_IDLE;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        out_valid = 1'b1;
        out_data  = sel_word;
        out_last  = pend_single;
        if (out_ready) begin
          pending_d = pending_q & ~low_oh;
          if (out_last) begin
            state_d   = ST_IDLE;
            pkt_cnt_d = pkt_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      logb_mask_q <= '0;
      loge_mask_q <= '0;
      data_q      <= '0;
      pending_q   <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      logb_mask_q <= logb_mask_d;
      loge_mask_q <= loge_mask_d;
      data_q      <= data_d;
      pending_q   <= pending_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rr_logb_serializer.sv
// Directed scoreboard bench for rr_logb_serializer: the driver queues the expected beats
// for each transaction, and a monitor running on the negative edge pops and compares them.
module tb_rr_logb_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   logb_valid;
  logic [255:0] logb_data;
  logic [3:0]   loge_valid;
  logic         ready;
  logic         out_valid;
  logic [63:0]  out_data;
  logic         out_last;
  logic         out_ready;
  logic [31:0]  pkt_cnt;
  logic         busy;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pkt = 32'd0;

  rr_logb_serializer #(
    .LOGB_CHANNEL_CNT(4),
    .LOGE_CHANNEL_CNT(4),
    .CH_WIDTH(64)
  ) dut (
    .clk(clk), .rst(rst),
    .logb_valid(logb_valid), .logb_data(logb_data), .loge_valid(loge_valid),
    .ready(ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .pkt_cnt(pkt_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops, stall stability, and zero data while idle.
  logic        hold_v = 1'b0;
  logic [63:0] hold_d;
  logic        hold_l;
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_valid", {63'd0, out_valid}, 64'd1);
          check("stall_data", out_data, hold_d);
          check("stall_last", {63'd0, out_last}, {63'd0, hold_l});
        end
        if (!out_valid) begin
          check("idle_data_zero", {out_data[62:0], out_last}, 64'd0);
        end else if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", out_data, 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", out_data, b.data);
            check("beat_last", {63'd0, out_last}, {63'd0, b.last});
          end
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_l = out_last;
      end
    end
  end

  task automatic send(input logic [3:0] lb, input logic [3:0] le,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic [63:0] d2, input logic [63:0] d3,
                      input logic [63:0] hdr);
    logic [63:0] d[4];
    logic [3:0]  rest;
    int n;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(negedge clk);
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("send_ready_timeout", {63'd0, ready}, 64'd1);
    logb_valid = lb;
    loge_valid = le;
    logb_data  = {d3, d2, d1, d0};
    exp_q.push_back('{data: hdr, last: (lb == 4'd0)});
    rest = lb;
    for (int i = 0; i < 4; i++) begin
      if (lb[i]) begin
        rest[i] = 1'b0;
        exp_q.push_back('{data: d[i], last: (rest == 4'd0)});
      end
    end
    exp_pkt = exp_pkt + 32'd1;
    @(posedge clk);
    #1;
    logb_valid = '0;
    loge_valid = '0;
    logb_data  = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      check({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int lowcnt;
    rst        = 1'b1;
    out_ready  = 1'b1;
    logb_valid = '0;
    loge_valid = '0;
    logb_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with all-zero inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {63'd0, ready}, 64'd1);
      check("idle_valid", {63'd0, out_valid}, 64'd0);
      check("idle_busy", {63'd0, busy}, 64'd0);
    end
    check("idle_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);

    // Two data channels plus a loge bit; ready must stay low for exactly 3 cycles
    send(4'b0101, 4'b0010, 64'hA, 64'hBAD1, 64'hC, 64'hBAD3, 64'h25);
    lowcnt = 0;
    @(negedge clk);
    while (!ready && lowcnt < 20) begin
      lowcnt++;
      @(negedge clk);
    end
    check("ready_low_cycles", 64'(lowcnt), 64'd3);
    wait_drain("t2");
    check("t2_pkt_cnt", {32'd0, pkt_cnt}, {32'd0, exp_pkt});

    // loge-only transaction: header is the whole packet
    send(4'b0000, 4'b1000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h80);
    wait_drain("t3");
    check("t3_pkt_cnt", {32'd0, pkt_cnt}, {32'd0, exp_pkt});

    // Single high channel
    send(4'b1000, 4'b0000, 64'h0, 64'h0, 64'h0, 64'h3333_4444_5555_6666, 64'h08);
    wait_drain("t3b");
    check("t3b_pkt_cnt", {32'd0, pkt_cnt}, {32'd0, exp_pkt});

    // All channels with out_ready toggling every cycle
    fork
      send(4'b1111, 4'b0000, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
           64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004, 64'h0F);
      for (int i = 0; i < 30; i++) begin
        @(posedge clk);
        #1 out_ready = ~out_ready;
      end
    join
    out_ready = 1'b1;
    wait_drain("t4");
    check("t4_pkt_cnt", {32'd0, pkt_cnt}, {32'd0, exp_pkt});

    // Reset in DATA with channels 1 and 2 still pending
    send(4'b0111, 4'b0001, 64'h71, 64'h72, 64'h73, 64'h0, 64'h17);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_pkt = 32'd0;
    @(negedge clk);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
    send(4'b0010, 4'b0000, 64'h0, 64'h5A5A, 64'h0, 64'h0, 64'h02);
    wait_drain("t5");
    check("t5_pkt_cnt", {32'd0, pkt_cnt}, 64'd1);

    // Counter wrap
    @(negedge clk);
    force dut.pkt_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.pkt_cnt_q;
    exp_pkt = 32'hFFFF_FFFE;
    @(negedge clk);
    check("wrap_preload", {32'd0, pkt_cnt}, 64'hFFFF_FFFE);
    send(4'b0000, 4'b0001, 64'h0, 64'h0, 64'h0, 64'h0, 64'h10);
    wait_drain("t6a");
    check("wrap_max", {32'd0, pkt_cnt}, 64'hFFFF_FFFF);
    send(4'b0000, 4'b0001, 64'h0, 64'h0, 64'h0, 64'h0, 64'h10);
    wait_drain("t6b");
    check("wrap_zero", {32'd0, pkt_cnt}, {32'd0, exp_pkt});

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
